// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock with a
// start/done handshake; divide-by-zero returns all-ones quotient and the dividend.
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH:0]   t, diff;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             busy_q, done_q, dbz_q;

    // The stored partial remainder is always below the divisor, so it fits in
    // WIDTH bits; the shifted trial value needs one more, and the borrow out of
    // the WIDTH+1-bit subtraction is the "doesn't fit" decision.
    always_comb begin
        t    = {r_q, q_q[WIDTH-1]};
        diff = t - {1'b0, d_q};
        q_d  = {q_q[WIDTH-2:0], 1'b0};
        r_d  = t[WIDTH-1:0];
        if (!diff[WIDTH]) begin
            r_d    = diff[WIDTH-1:0];
            q_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        d_q <= divisor;
                        if (divisor != '0) begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            r_q     <= '0;
                            q_q     <= dividend;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= q_d;
                        rem_q   <= r_d;
                        dbz_q   <= 1'b0;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule
